// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: memory controller request/response plus the decoder-facing FIFO head.
// master is the fetch queue; slave is the environment (controller + decoder).
interface inst_fetch_queue_if;
  logic        mc_en;
  logic [31:0] mc_addr;
  logic        mc_rdy;
  logic [31:0] mc_data;
  logic        mc_is_compressed;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_is_compressed;
  logic        out_ready;

  modport master (
    output mc_en, mc_addr, out_valid, out_inst, out_pc, out_is_compressed,
    input  mc_rdy, mc_data, mc_is_compressed, out_ready
  );

  modport slave (
    input  mc_en, mc_addr, out_valid, out_inst, out_pc, out_is_compressed,
    output mc_rdy, mc_data, mc_is_compressed, out_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues one fetch at a time to the memory
// controller and buffers results in a DEPTH-entry FIFO toward the decoder.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  inst_fetch_queue_if.master    bus
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {IDLE, WAIT} fetch_state_t;

  fetch_state_t     fetch_state, state_next;
  logic [31:0]      pc, mc_addr_q, pc_next;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count, count_next;
  logic             push, pop;

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic             c_mem    [DEPTH];

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    count_next = count;
    state_next = fetch_state;
    pc_next    = mc_addr_q + (bus.mc_is_compressed ? 32'd2 : 32'd4);

    // A flush discards any response or pop that lands on the same edge.
    if (!flush) begin
      push = (fetch_state == WAIT) && bus.mc_rdy;
      pop  = (count != '0) && bus.out_ready;
    end

    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase

    if (flush) begin
      state_next = IDLE;
    end else begin
      case (fetch_state)
        IDLE:    if (count < CNT_FULL) state_next = WAIT;
        WAIT:    if (push && (count_next >= CNT_FULL)) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_state <= IDLE;
    end else if (rdy_in) begin
      fetch_state <= state_next;
    end
  end

  // Storage is cleared on reset so the head fields read zero until the first push.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc        <= RESET_PC;
      mc_addr_q <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
        c_mem[i]    <= 1'b0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        pc        <= flush_pc;
        mc_addr_q <= flush_pc;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
      end else begin
        if (fetch_state == IDLE && state_next == WAIT) begin
          mc_addr_q <= pc;
        end
        if (push) begin
          inst_mem[tail] <= bus.mc_data;
          pc_mem[tail]   <= mc_addr_q;
          c_mem[tail]    <= bus.mc_is_compressed;
          tail           <= tail + PTR_ONE;
          pc             <= pc_next;
          mc_addr_q      <= pc_next;
        end
        if (pop) begin
          head <= head + PTR_ONE;
        end
        count <= count_next;
      end
    end
  end

  assign bus.mc_en             = (fetch_state == WAIT);
  assign bus.mc_addr           = mc_addr_q;
  assign bus.out_valid         = (count != '0);
  assign bus.out_inst          = inst_mem[head];
  assign bus.out_pc            = pc_mem[head];
  assign bus.out_is_compressed = c_mem[head];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: the bench plays memory controller and decoder,
// recording each delivered fetch in a scoreboard that is checked as the decoder pops.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        c;
  } entry_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush;
  logic [31:0] flush_pc;

  inst_fetch_queue_if ifc ();

  int          checks   = 0;
  int          failures = 0;
  entry_t      sb[$];
  logic [31:0] exp_addr;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .flush    (flush),
    .flush_pc (flush_pc),
    .bus      (ifc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are already set for the coming edge; compare the head if it will be popped.
  task automatic tick();
    entry_t e;
    check_output("out_valid", {31'b0, ifc.out_valid}, {31'b0, sb.size() != 0});
    if (rdy_in && !flush && ifc.out_valid === 1'b1 && ifc.out_ready && sb.size() != 0) begin
      e = sb.pop_front();
      check_output("out_inst", ifc.out_inst, e.inst);
      check_output("out_pc", ifc.out_pc, e.pc);
      check_output("out_is_compressed", {31'b0, ifc.out_is_compressed}, {31'b0, e.c});
    end
    @(negedge clk_in);
  endtask

  // Controller model: wait for a request, hold it for latency cycles, then answer.
  task automatic serve_fetch(input logic [31:0] data, input logic c, input int latency);
    int n = 0;
    while (ifc.mc_en !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_output("mc_en_req", {31'b0, ifc.mc_en}, 32'd1);
    check_output("mc_addr_req", ifc.mc_addr, exp_addr);
    for (int i = 0; i < latency; i++) begin
      tick();
      check_output("mc_en_hold", {31'b0, ifc.mc_en}, 32'd1);
      check_output("mc_addr_hold", ifc.mc_addr, exp_addr);
    end
    ifc.mc_rdy           = 1'b1;
    ifc.mc_data          = data;
    ifc.mc_is_compressed = c;
    tick();
    ifc.mc_rdy           = 1'b0;
    ifc.mc_data          = '0;
    ifc.mc_is_compressed = 1'b0;
    sb.push_back('{data, exp_addr, c});
    exp_addr = exp_addr + (c ? 32'd2 : 32'd4);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n_in             = 1'b0;
    rdy_in               = 1'b1;
    flush                = 1'b0;
    flush_pc             = '0;
    ifc.mc_rdy           = 1'b0;
    ifc.mc_data          = '0;
    ifc.mc_is_compressed = 1'b0;
    ifc.out_ready        = 1'b1;
    exp_addr             = RESET_PC;

    // Reset state
    repeat (2) @(negedge clk_in);
    check_output("rst_mc_en", {31'b0, ifc.mc_en}, 32'd0);
    check_output("rst_mc_addr", ifc.mc_addr, RESET_PC);
    check_output("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    check_output("rst_out_inst", ifc.out_inst, 32'd0);
    check_output("rst_out_pc", ifc.out_pc, 32'd0);
    check_output("rst_out_c", {31'b0, ifc.out_is_compressed}, 32'd0);
    rst_n_in = 1'b1;

    // Uncompressed stream from RESET_PC, decoder always ready
    tick();
    check_output("first_mc_en", {31'b0, ifc.mc_en}, 32'd1);
    serve_fetch(32'hAAAA_0100, 1'b0, 2);
    check_output("b2b_mc_en", {31'b0, ifc.mc_en}, 32'd1);
    check_output("b2b_mc_addr", ifc.mc_addr, 32'h104);
    serve_fetch(32'hAAAA_0104, 1'b0, 2);
    serve_fetch(32'hAAAA_0108, 1'b0, 2);
    repeat (2) tick();

    // Mixed compressed / uncompressed stream from 0x0
    flush    = 1'b1;
    flush_pc = 32'h0;
    tick();
    flush = 1'b0;
    sb.delete();
    exp_addr = 32'h0;
    check_output("flush0_mc_en", {31'b0, ifc.mc_en}, 32'd0);
    serve_fetch(32'hBBBB_0000, 1'b1, 1);
    serve_fetch(32'hBBBB_0002, 1'b0, 1);
    serve_fetch(32'hBBBB_0006, 1'b1, 1);
    check_output("mixed_next_addr", ifc.mc_addr, 32'h8);
    repeat (3) tick();

    // Decoder stalled: FIFO fills, fetching stops, one pop restarts it
    ifc.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) serve_fetch(32'hCCCC_0000 | exp_addr, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      check_output("full_mc_en", {31'b0, ifc.mc_en}, 32'd0);
      check_output("full_out_pc", ifc.out_pc, 32'h8);
      tick();
    end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check_output("pop_t_mc_en", {31'b0, ifc.mc_en}, 32'd0);
    check_output("pop_next_pc", ifc.out_pc, 32'hC);
    tick();
    check_output("pop_t1_mc_en", {31'b0, ifc.mc_en}, 32'd1);
    check_output("pop_t1_mc_addr", ifc.mc_addr, 32'h18);

    // Flush coinciding with a response while two entries are queued
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    ifc.mc_rdy    = 1'b1;
    ifc.mc_data   = 32'hDEAD_BEEF;
    flush         = 1'b1;
    flush_pc      = 32'h2000;
    tick();
    ifc.mc_rdy  = 1'b0;
    ifc.mc_data = '0;
    flush       = 1'b0;
    sb.delete();
    exp_addr = 32'h2000;
    check_output("flush_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    check_output("flush_mc_en", {31'b0, ifc.mc_en}, 32'd0);
    check_output("flush_mc_addr", ifc.mc_addr, 32'h2000);
    tick();
    check_output("flush_t1_mc_en", {31'b0, ifc.mc_en}, 32'd1);
    check_output("flush_t1_mc_addr", ifc.mc_addr, 32'h2000);

    // Global stall mid-WAIT: responses and pops are ignored
    serve_fetch(32'hEEEE_2000, 1'b0, 1);
    rdy_in        = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifc.mc_rdy  = 1'b1;
      ifc.mc_data = 32'h5555_0000 + 32'(i);
      tick();
      check_output("stall_mc_en", {31'b0, ifc.mc_en}, 32'd1);
      check_output("stall_mc_addr", ifc.mc_addr, 32'h2004);
      check_output("stall_out_pc", ifc.out_pc, 32'h2000);
    end
    ifc.mc_rdy  = 1'b0;
    ifc.mc_data = '0;
    rdy_in      = 1'b1;
    serve_fetch(32'hEEEE_2004, 1'b0, 2);
    repeat (3) tick();

    // Asynchronous reset between edges with three entries queued
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) serve_fetch(32'hF0F0_0000 | exp_addr, 1'b0, 1);
    check_output("pre_rst_mc_en", {31'b0, ifc.mc_en}, 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    check_output("arst_mc_en", {31'b0, ifc.mc_en}, 32'd0);
    check_output("arst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    check_output("arst_mc_addr", ifc.mc_addr, RESET_PC);
    check_output("arst_out_pc", ifc.out_pc, 32'd0);
    sb.delete();
    @(negedge clk_in);
    rst_n_in      = 1'b1;
    exp_addr      = RESET_PC;
    ifc.out_ready = 1'b1;
    serve_fetch(32'h1234_5678, 1'b1, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end that sits directly upstream of the memory controller's decoder port. It owns the fetch PC, issues one instruction fetch at a time over the controller's en/addr/rdy handshake, and advances the PC by 2 or 4 according to the controller's compressed flag. Fetched instructions are buffered in a DEPTH-entry FIFO toward the decoder, and the whole block is redirected on flush.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0: fetch PC after reset.

- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; when low, all state is frozen.
- flush  in  1  redirect request; acts only when rdy_in=1.
- flush_pc  in  32  new fetch PC, valid with flush.
- mc_en  out  1  fetch request to memory controller.
- mc_addr  out  32  fetch byte address; held stable while mc_en=1 and mc_rdy=0.
- mc_rdy  in  1  fetch done; one-cycle pulse.
- mc_data  in  32  fetched (already decompressed) instruction; valid with mc_rdy.
- mc_is_compressed  in  1  source was 16-bit; valid with mc_rdy.
- out_valid  out  1  FIFO head valid.
- out_inst  out  32  head instruction.
- out_pc  out  32  head instruction address.
- out_is_compressed  out  1  head compressed flag.
- out_ready  in  1  decoder accepts head this cycle.

## Operation
- Storage:
  - DEPTH entries of {inst[31:0], pc[31:0], c}.
  - Head and tail pointers of log2(DEPTH) bits wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- FSM fetch_state: IDLE (mc_en=0), WAIT (mc_en=1).
  - IDLE→WAIT when count<DEPTH. mc_addr ← pc.
  - WAIT, mc_rdy=0: hold. mc_en and mc_addr must not change.
  - WAIT, mc_rdy=1:
    - Push {mc_data, mc_addr, mc_is_compressed}.
    - pc ← mc_addr + (mc_is_compressed ? 2 : 4), 32-bit wrap.
    - mc_addr ← that new pc.
    - Stay in WAIT if count_next<DEPTH; otherwise go to IDLE.
- Only one fetch is in flight. Fetches are issued only with space available, and while waiting count can only fall, so a push never finds the FIFO full. This is asserted in verification.
- Pop: when out_valid && out_ready, head advances.
  - out_ready with out_valid=0 is ignored.
  - Push and pop in the same cycle leave count unchanged. When count=0, this case cannot occur because out_valid=0.
- Output: out_valid = (count≠0). out_* is read combinationally from the registered head entry.
- Flush (flush && rdy_in): highest priority over reset-free activity.
  - count ← 0, head ← tail ← 0.
  - pc ← mc_addr ← flush_pc.
  - fetch_state ← IDLE, mc_en ← 0.
  - A same-cycle mc_rdy and a same-cycle pop are discarded. The memory controller abandons its in-flight access on the same edge.
- rdy_in=0: no state change. mc_rdy and out_ready are ignored, and outputs hold.
- Reset (asynchronous, any time, including mid-fetch):
  - fetch_state=IDLE, mc_en=0, mc_addr=RESET_PC, pc=RESET_PC.
  - count=0, head=tail=0, out_valid=0.
  - Stored entries are don't-care, but out_inst/out_pc/out_is_compressed read 0 after reset.

## Timing
- After reset release, the first rdy_in=1 edge moves to WAIT, and mc_en=1 appears in the following cycle.
- mc_rdy sampled high at edge t gives out_valid=1 with that entry after t, if the FIFO was empty. A new mc_addr is presented after t as well.
- The controller has its own cooldown; mc_en stays high continuously across back-to-back fetches with the updated address.
- Flush at edge t: mc_en=0 and out_valid=0 after t. mc_en=1 with mc_addr=flush_pc after t+1.
- A pop at edge t makes the next entry visible after t with no bubble.
- Full at edge t with a pop at t: IDLE→WAIT on edge t+1.
- Throughput is bounded by the controller, at about 7 cycles per 32-bit fetch.

## Test plan
- Reset, RESET_PC=0x100, controller model returns uncompressed words with out_ready=1 → mc_addr sequence 0x100, 0x104, 0x108; out_pc matches, out_is_compressed=0.
- Mixed stream: compressed at 0x0, uncompressed at 0x2, compressed at 0x6 → mc_addr 0x0, 0x2, 0x6, 0x8; out_pc 0x0, 0x2, 0x6.
- out_ready=0 with DEPTH=4 → exactly 4 pushes, then mc_en=0 and out_valid=1 stays steady. Raise out_ready for 1 cycle → the next cycle mc_en=1, and the addresses continue without a gap.
- Flush with flush_pc=0x2000 in the same cycle as mc_rdy with count=2 → the entry is dropped, out_valid=0 next cycle, and the next fetch address is 0x2000.
- rdy_in=0 for 5 cycles mid-WAIT while mc_rdy is pulsed → no push, and mc_addr and count are unchanged. Resume → normal operation.
- Assert rst_n_in asynchronously between edges during WAIT with count=3 → mc_en=0, out_valid=0 immediately, and mc_addr=RESET_PC.
